// File: rtl/sd_xfer_sched_if.sv
// Signal bundle between the transfer scheduler, the SD SPI controller top
// and the two job requesters. Signal names match the original flat ports.
interface sd_xfer_sched_if #(
  parameter int CNT_W = 16
);
  // SD controller side
  logic             sd_init_done;
  logic             sd_wr_busy;
  logic             sd_rd_busy;
  logic             sd_wr_start_en;
  logic [31:0]      sd_wr_sec_addr;
  logic             sd_rd_start_en;
  logic [31:0]      sd_rd_sec_addr;

  // Requester 0
  logic             r0_valid;
  logic             r0_ready;
  logic             r0_wr;
  logic [31:0]      r0_sec;
  logic [CNT_W-1:0] r0_cnt;

  // Requester 1
  logic             r1_valid;
  logic             r1_ready;
  logic             r1_wr;
  logic [31:0]      r1_sec;
  logic [CNT_W-1:0] r1_cnt;

  // Job status
  logic             active;
  logic             active_id;
  logic [CNT_W-1:0] sec_left;
  logic             done_valid;
  logic             done_id;
  logic             done_err;

  // Scheduler view
  modport master (
    input  sd_init_done, sd_wr_busy, sd_rd_busy,
    output sd_wr_start_en, sd_wr_sec_addr, sd_rd_start_en, sd_rd_sec_addr,
    input  r0_valid, r0_wr, r0_sec, r0_cnt,
    output r0_ready,
    input  r1_valid, r1_wr, r1_sec, r1_cnt,
    output r1_ready,
    output active, active_id, sec_left, done_valid, done_id, done_err
  );

  // Environment view (controller, requesters, status consumer)
  modport slave (
    output sd_init_done, sd_wr_busy, sd_rd_busy,
    input  sd_wr_start_en, sd_wr_sec_addr, sd_rd_start_en, sd_rd_sec_addr,
    output r0_valid, r0_wr, r0_sec, r0_cnt,
    input  r0_ready,
    output r1_valid, r1_wr, r1_sec, r1_cnt,
    input  r1_ready,
    input  active, active_id, sec_left, done_valid, done_id, done_err
  );
endinterface

// File: rtl/sd_xfer_sched.sv
// Multi-sector transfer scheduler in front of the SD SPI controller.
// Arbitrates round-robin between two requesters, then issues one start
// strobe per sector and follows the controller busy flag to completion.
// All outputs except the ready handshakes are registered.
module sd_xfer_sched #(
  parameter int CNT_W    = 16,
  parameter int START_TO = 255
) (
  input logic               clk_ref,
  input logic               rst_n,
  sd_xfer_sched_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(START_TO);

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [31:0]      sec_q, sec_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [7:0]       to_q, to_d;
  logic             err_q, err_d;
  logic             rr_q, rr_d;
  logic             active_q, active_d;
  logic             id_q, id_d;
  logic             wr_start_q, wr_start_d;
  logic             rd_start_q, rd_start_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic             done_valid_q, done_valid_d;
  logic             done_id_q, done_id_d;
  logic             done_err_q, done_err_d;

  logic             grant_id;
  logic             any_valid;
  logic             accept_ok;
  logic             busy_sel;
  logic             abort;
  logic [7:0]       to_inc;

  // Round-robin pick: pointer decides only when both requesters are valid
  always_comb begin
    any_valid = bus.r0_valid | bus.r1_valid;
    grant_id  = (bus.r0_valid & bus.r1_valid) ? rr_q : bus.r1_valid;
    accept_ok = (state_q == S_IDLE) & bus.sd_init_done;
  end

  assign bus.r0_ready = accept_ok & bus.r0_valid & ~grant_id;
  assign bus.r1_ready = accept_ok & bus.r1_valid &  grant_id;

  assign busy_sel = wr_q ? bus.sd_wr_busy : bus.sd_rd_busy;
  assign abort    = ~bus.sd_init_done;
  assign to_inc   = to_q + 8'd1;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    sec_d        = sec_q;
    left_d       = left_q;
    to_d         = to_q;
    err_d        = err_q;
    rr_d         = rr_q;
    active_d     = active_q;
    id_d         = id_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    done_id_d    = done_id_q;
    done_err_d   = done_err_q;
    wr_start_d   = 1'b0;
    rd_start_d   = 1'b0;
    done_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_ok && any_valid) begin
          id_d     = grant_id;
          wr_d     = grant_id ? bus.r1_wr  : bus.r0_wr;
          sec_d    = grant_id ? bus.r1_sec : bus.r0_sec;
          left_d   = grant_id ? bus.r1_cnt : bus.r0_cnt;
          active_d = 1'b1;
          if ((grant_id ? bus.r1_cnt : bus.r0_cnt) == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!bus.sd_wr_busy && !bus.sd_rd_busy) begin
          if (wr_q) begin
            wr_start_d = 1'b1;
            wr_addr_d  = sec_q;
          end else begin
            rd_start_d = 1'b1;
            rd_addr_d  = sec_q;
          end
          to_d    = '0;
          state_d = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (busy_sel) begin
          state_d = S_WAIT_DONE;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_LIM) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!busy_sel) begin
          if (left_q == CNT_W'(1)) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            sec_d   = sec_q + 32'd1;
            left_d  = left_q - CNT_W'(1);
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end

      S_DONE: begin
        done_valid_d = 1'b1;
        done_id_d    = id_q;
        done_err_d   = err_q;
        active_d     = 1'b0;
        rr_d         = ~rr_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      sec_q        <= '0;
      left_q       <= '0;
      to_q         <= '0;
      err_q        <= 1'b0;
      rr_q         <= 1'b0;
      active_q     <= 1'b0;
      id_q         <= 1'b0;
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      sec_q        <= sec_d;
      left_q       <= left_d;
      to_q         <= to_d;
      err_q        <= err_d;
      rr_q         <= rr_d;
      active_q     <= active_d;
      id_q         <= id_d;
      wr_start_q   <= wr_start_d;
      rd_start_q   <= rd_start_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
    end
  end

  assign bus.sd_wr_start_en = wr_start_q;
  assign bus.sd_rd_start_en = rd_start_q;
  assign bus.sd_wr_sec_addr = wr_addr_q;
  assign bus.sd_rd_sec_addr = rd_addr_q;
  assign bus.active         = active_q;
  assign bus.active_id      = id_q;
  assign bus.sec_left       = left_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_id        = done_id_q;
  assign bus.done_err       = done_err_q;

endmodule

// File: tb/tb_sd_xfer_sched.sv
// Directed bench for sd_xfer_sched with a simple busy model of the
// SD controller (busy rises the cycle after a start pulse, lasts BUSY_LEN).
module tb_sd_xfer_sched;
  localparam int CNT_W    = 16;
  localparam int TO       = 255;
  localparam int BUSY_LEN = 10;

  logic clk_ref = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_ref = ~clk_ref;

  sd_xfer_sched_if #(.CNT_W(CNT_W)) bus ();

  sd_xfer_sched #(.CNT_W(CNT_W), .START_TO(TO)) dut (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Controller busy model
  logic        busy_en;
  int unsigned rd_left, wr_left;
  always @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      rd_left <= 0;
      wr_left <= 0;
    end else begin
      if (bus.sd_rd_start_en && busy_en) rd_left <= BUSY_LEN;
      else if (rd_left != 0)             rd_left <= rd_left - 1;
      if (bus.sd_wr_start_en && busy_en) wr_left <= BUSY_LEN;
      else if (wr_left != 0)             wr_left <= wr_left - 1;
    end
  end
  assign bus.sd_rd_busy = (rd_left != 0);
  assign bus.sd_wr_busy = (wr_left != 0);

  // Cycle counter and event log
  int unsigned cyc = 0;
  always @(posedge clk_ref) cyc <= cyc + 1;

  logic [31:0] rd_addr[$];
  int unsigned rd_sl[$];
  logic        done_ids[$];
  int unsigned wr_n = 0, done_n = 0;
  int unsigned wr_cyc_last = 0, done_cyc = 0;
  logic [31:0] wr_addr_last = '0;
  logic        done_err_last = 1'b0;

  always @(negedge clk_ref) begin
    if (bus.sd_rd_start_en) begin
      rd_addr.push_back(bus.sd_rd_sec_addr);
      rd_sl.push_back(int'(bus.sec_left));
    end
    if (bus.sd_wr_start_en) begin
      wr_n         = wr_n + 1;
      wr_cyc_last  = cyc;
      wr_addr_last = bus.sd_wr_sec_addr;
    end
    if (bus.done_valid) begin
      done_n        = done_n + 1;
      done_cyc      = cyc;
      done_err_last = bus.done_err;
      done_ids.push_back(bus.done_id);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned start;
    int unsigned k;
    start = done_n;
    k = 0;
    while (done_n == start && k < budget) begin
      @(negedge clk_ref); #1;
      k++;
    end
    chk("done_seen", 64'(done_n != start), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int unsigned base, rc, wr0, k;

  initial begin
    busy_en          = 1'b1;
    bus.sd_init_done = 1'b0;
    bus.r0_valid = 1'b0; bus.r0_wr = 1'b0; bus.r0_sec = '0; bus.r0_cnt = '0;
    bus.r1_valid = 1'b0; bus.r1_wr = 1'b0; bus.r1_sec = '0; bus.r1_cnt = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_ref);
    #1;

    // Reset values
    chk("rst_active",     64'(bus.active),         64'd0);
    chk("rst_active_id",  64'(bus.active_id),      64'd0);
    chk("rst_sec_left",   64'(bus.sec_left),       64'd0);
    chk("rst_done_valid", 64'(bus.done_valid),     64'd0);
    chk("rst_rd_start",   64'(bus.sd_rd_start_en), 64'd0);
    chk("rst_wr_start",   64'(bus.sd_wr_start_en), 64'd0);
    chk("rst_rd_addr",    64'(bus.sd_rd_sec_addr), 64'd0);
    chk("rst_wr_addr",    64'(bus.sd_wr_sec_addr), 64'd0);
    bus.r0_valid = 1'b1;
    #1 chk("rst_r0_ready", 64'(bus.r0_ready), 64'd0);
    @(negedge clk_ref); #1;
    rst_n = 1'b1;
    #1 chk("noinit_r0_ready", 64'(bus.r0_ready), 64'd0);

    // Single read: 3 sectors from 0x100
    bus.r0_wr = 1'b0; bus.r0_sec = 32'h100; bus.r0_cnt = 16'd3;
    bus.sd_init_done = 1'b1;
    #1;
    chk("rd_r0_ready", 64'(bus.r0_ready), 64'd1);
    chk("rd_r1_ready", 64'(bus.r1_ready), 64'd0);
    @(posedge clk_ref); #1;
    bus.r0_valid = 1'b0;
    chk("rd_active",   64'(bus.active),   64'd1);
    chk("rd_sec_left", 64'(bus.sec_left), 64'd3);
    wait_done(200);
    chk("rd_pulses",  64'(rd_addr.size()), 64'd3);
    if (rd_addr.size() == 3) begin
      chk("rd_addr0", 64'(rd_addr[0]), 64'h100);
      chk("rd_addr1", 64'(rd_addr[1]), 64'h101);
      chk("rd_addr2", 64'(rd_addr[2]), 64'h102);
      chk("rd_left0", 64'(rd_sl[0]), 64'd3);
      chk("rd_left1", 64'(rd_sl[1]), 64'd2);
      chk("rd_left2", 64'(rd_sl[2]), 64'd1);
    end
    chk("rd_no_wr",    64'(wr_n),         64'd0);
    chk("rd_done_id",  64'(bus.done_id),  64'd0);
    chk("rd_done_err", 64'(bus.done_err), 64'd0);
    chk("rd_inactive", 64'(bus.active),   64'd0);
    @(negedge clk_ref); #1;
    chk("rd_done_one_cycle", 64'(bus.done_valid), 64'd0);

    // Contention: fresh reset, both requesters held valid for four jobs
    rst_n = 1'b0;
    @(negedge clk_ref); #1;
    rst_n = 1'b1;
    rd_addr.delete(); rd_sl.delete(); done_ids.delete();
    bus.r0_wr = 1'b0; bus.r0_sec = 32'h200; bus.r0_cnt = 16'd1;
    bus.r1_wr = 1'b0; bus.r1_sec = 32'h300; bus.r1_cnt = 16'd1;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    chk("ct_r0_ready_first", 64'(bus.r0_ready), 64'd1);
    chk("ct_r1_ready_first", 64'(bus.r1_ready), 64'd0);
    wait_done(100);
    chk("ct_done0_id",   64'(bus.done_id),  64'd0);
    chk("ct_r1_ready_2", 64'(bus.r1_ready), 64'd1);
    chk("ct_r0_ready_2", 64'(bus.r0_ready), 64'd0);
    wait_done(100);
    chk("ct_done1_id",   64'(bus.done_id),  64'd1);
    chk("ct_r0_ready_3", 64'(bus.r0_ready), 64'd1);
    wait_done(100);
    chk("ct_done2_id",   64'(bus.done_id),  64'd0);
    wait_done(100);
    chk("ct_done3_id",   64'(bus.done_id),  64'd1);
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    chk("ct_pulses", 64'(rd_addr.size()), 64'd4);
    if (rd_addr.size() == 4) begin
      chk("ct_addr0", 64'(rd_addr[0]), 64'h200);
      chk("ct_addr1", 64'(rd_addr[1]), 64'h300);
      chk("ct_addr2", 64'(rd_addr[2]), 64'h200);
      chk("ct_addr3", 64'(rd_addr[3]), 64'h300);
    end

    // Timeout: r1 write, busy never rises
    busy_en = 1'b0;
    base = rd_addr.size();
    wr0  = wr_n;
    bus.r1_wr = 1'b1; bus.r1_sec = 32'h55; bus.r1_cnt = 16'd1;
    bus.r1_valid = 1'b1;
    #1 chk("to_r1_ready", 64'(bus.r1_ready), 64'd1);
    @(posedge clk_ref); #1;
    bus.r1_valid = 1'b0;
    wait_done(TO + 20);
    chk("to_wr_pulses", 64'(wr_n - wr0),          64'd1);
    chk("to_wr_addr",   64'(wr_addr_last),        64'h55);
    chk("to_latency",   64'(done_cyc - wr_cyc_last), 64'(TO + 1));
    chk("to_done_id",   64'(bus.done_id),         64'd1);
    chk("to_done_err",  64'(bus.done_err),        64'd1);
    chk("to_no_rd",     64'(rd_addr.size()),      64'(base));
    busy_en = 1'b1;

    // Zero count: done two cycles after ready, no start pulse
    @(negedge clk_ref); #1;
    wr0 = wr_n;
    bus.r0_wr = 1'b0; bus.r0_sec = 32'h77; bus.r0_cnt = 16'd0;
    bus.r0_valid = 1'b1;
    #1;
    chk("zc_r0_ready", 64'(bus.r0_ready), 64'd1);
    rc = cyc;
    @(posedge clk_ref); #1;
    bus.r0_valid = 1'b0;
    wait_done(20);
    chk("zc_latency",  64'(done_cyc - rc),   64'd2);
    chk("zc_done_id",  64'(bus.done_id),     64'd0);
    chk("zc_done_err", 64'(done_err_last),   64'd1);
    chk("zc_no_rd",    64'(rd_addr.size()),  64'(base));
    chk("zc_no_wr",    64'(wr_n),            64'(wr0));

    // Wrap from 0xFFFFFFFF, then abort during the second WAIT_DONE
    @(negedge clk_ref); #1;
    bus.r0_wr = 1'b0; bus.r0_sec = 32'hFFFF_FFFF; bus.r0_cnt = 16'd2;
    bus.r0_valid = 1'b1;
    @(posedge clk_ref); #1;
    bus.r0_valid = 1'b0;
    k = 0;
    while (rd_addr.size() < base + 2 && k < 100) begin
      @(negedge clk_ref); #1;
      k++;
    end
    chk("wa_two_pulses", 64'(rd_addr.size()), 64'(base + 2));
    k = 0;
    while (!bus.sd_rd_busy && k < 10) begin
      @(negedge clk_ref); #1;
      k++;
    end
    chk("wa_busy_seen", 64'(bus.sd_rd_busy), 64'd1);
    @(negedge clk_ref); #1;
    bus.sd_init_done = 1'b0;
    wait_done(20);
    chk("wa_done_id",  64'(bus.done_id),  64'd0);
    chk("wa_done_err", 64'(bus.done_err), 64'd1);
    if (rd_addr.size() >= base + 2) begin
      chk("wa_addr0", 64'(rd_addr[base]),     64'hFFFF_FFFF);
      chk("wa_addr1", 64'(rd_addr[base + 1]), 64'h0);
      chk("wa_left1", 64'(rd_sl[base + 1]),   64'd1);
    end
    repeat (30) @(negedge clk_ref);
    #1;
    chk("wa_no_more_rd", 64'(rd_addr.size()), 64'(base + 2));
    chk("wa_no_wr",      64'(wr_n),           64'(wr0));
    chk("wa_inactive",   64'(bus.active),     64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
